crash_detect: RTL
=================

// Module: crash_detect
// PURPOSE
//  Per-pixel collision detector that drives the crash inputs of the enemy layers (enemy1..enemy3).
//  It compares the alpha outputs of the me, bullet and enemy layers during the VGA scan.
//  It issues zero-latency crash pulses, aligned with the overlapping pixel, so that each enemy
//  module's current-enemy index is still valid when the pulse arrives.
//  Pulses are rate-limited per frame, and an invincibility window follows each me hit.
// PARAMETERS
//  LAYERS            3   number of enemy layers (bit k of the vectors = enemy layer k)
//  INV_FRAMES        60  frames of me invincibility after a me crash (1..255)
//  INV_CNT_BIT_LEN   8   width of the invincibility frame counter
// PORTS
//  clk_vga               in   1       pixel clock; all state on rising edge
//  rst_n                 in   1       synchronous reset, active low
//  en_i                  in   1       game running; low => outputs 0, per-frame flags cleared
//  v_sync_i              in   1       VGA vsync (active low); falling edge = frame start
//  me_alpha_i            in   1       me plane pixel opaque at current scan position
//  bullet_alpha_i        in   1       any bullet pixel opaque at current scan position
//  enemy_alpha_i         in   LAYERS  per-layer enemy pixel opaque (already BRAM-aligned)
//  crash_enemy_bullet_o  out  LAYERS  bullet hit pulse to layer k (1 clk_vga cycle)
//  crash_me_enemy_o      out  LAYERS  me-vs-enemy pulse to layer k (1 cycle)
//  me_hit_o              out  1       OR of crash_me_enemy_o; feeds me/life logic
//  invincible_o          out  1       high while invincibility counter != 0
// BEHAVIOUR
//  - Reset (rst_n=0 at clock edge):
//    - clears v_sync_d (to 1), bullet_done[LAYERS], me_done and inv_cnt.
//    - All outputs are 0 while rst_n=0 and on the following cycle unless an overlap occurs.
//  - frame_start = v_sync_d & ~v_sync_i (registered previous vsync, combinational edge).
//  - Outputs are combinational from the inputs and the registered flags; latency is 0 cycles.
//    - ov_me[k] = en_i & me_alpha_i & enemy_alpha_i[k]
//    - ov_bu[k] = en_i & bullet_alpha_i & enemy_alpha_i[k]
//  - fresh = frame_start: the flags are treated as cleared in the frame_start cycle itself.
//  - Me crash:
//    - Allowed only when inv_cnt==0 and (~me_done | fresh).
//    - Only the lowest-index k with ov_me[k] gets the pulse.
//    - At most one me crash pulse per frame across all layers.
//  - Bullet crash, for layer k:
//    - Pulses when ov_bu[k] & (~bullet_done[k] | fresh).
//    - Suppressed in any cycle where crash_me_enemy_o[k] is high (me crash has priority).
//    - At most one bullet pulse per layer per frame; different layers may pulse in the same cycle.
//  - Flag update each cycle, in priority order:
//    - ~en_i => all flags 0.
//    - Else bit set on pulse.
//    - Else bits cleared on frame_start.
//    - Else hold.
//  - Invincibility counter, in priority order:
//    - me_hit_o => inv_cnt <= INV_FRAMES. Load wins over a simultaneous frame_start.
//    - Else frame_start & inv_cnt!=0 => decrement.
//    - Else hold.
//    - en_i low does not clear inv_cnt; only reset does.
//  - invincible_o = (inv_cnt != 0), registered-state-derived.
//  - v_sync_d <= v_sync_i every cycle (also while en_i low).
//  - Reset mid-frame: all flags drop. The next overlap after release may pulse immediately.
//  - inv_cnt saturates: never decrements below 0, never exceeds INV_FRAMES.
// TESTING
//  1. Reset, en_i=1, bullet and enemy_alpha[1] overlap for 5 cycles:
//     crash_enemy_bullet_o=3'b010 on the first cycle only. Give a vsync falling edge,
//     then overlap again => one more pulse.
//  2. me_alpha & enemy_alpha=3'b110 in the same cycle:
//     crash_me_enemy_o=3'b010, me_hit_o=1, invincible_o=1 next cycle.
//     Further overlaps give no pulse for exactly 60 frame starts.
//  3. me, bullet and enemy[0] all overlap in the same cycle:
//     crash_me_enemy_o[0]=1, crash_enemy_bullet_o[0]=0.
//     A later bullet-only overlap in the same frame gives crash_enemy_bullet_o[0]=1.
//  4. Overlap in the exact frame_start cycle while the flag is set from the previous frame:
//     pulse is issued, and the flag remains set afterwards.
//  5. Drop en_i mid-frame after a hit, then raise it:
//     outputs are 0 while low, and the next overlap pulses again. inv_cnt continues unchanged.
//  6. Assert rst_n=0 for one cycle during invincibility: inv_cnt=0 and invincible_o=0 after the edge.

Source files
------------

// File: rtl/crash_detect.sv
// Per-pixel collision detector for the enemy layers.
// Crash pulses are combinational from the current alpha inputs, so they line up with
// the overlapping pixel while each enemy module's current-enemy index is still valid.
// Registered per-frame "done" flags limit how often pulses can fire. An invincibility
// counter, counted in frames, blocks me hits for a while after each me hit.
module crash_detect #(
  parameter int LAYERS          = 3,
  parameter int INV_FRAMES      = 60,
  parameter int INV_CNT_BIT_LEN = 8
) (
  input  logic              clk_vga,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              v_sync_i,
  input  logic              me_alpha_i,
  input  logic              bullet_alpha_i,
  input  logic [LAYERS-1:0] enemy_alpha_i,
  output logic [LAYERS-1:0] crash_enemy_bullet_o,
  output logic [LAYERS-1:0] crash_me_enemy_o,
  output logic              me_hit_o,
  output logic              invincible_o
);

  localparam logic [INV_CNT_BIT_LEN-1:0] INV_LOAD = INV_CNT_BIT_LEN'(INV_FRAMES);

  logic                       v_sync_d;
  logic [LAYERS-1:0]          bullet_done;
  logic                       me_done;
  logic [INV_CNT_BIT_LEN-1:0] inv_cnt;

  logic              frame_start;
  logic              active;
  logic              me_ok;
  logic [LAYERS-1:0] ov_me;
  logic [LAYERS-1:0] ov_bu;
  logic [LAYERS-1:0] me_pick;
  logic [LAYERS-1:0] bu_pick;

  // The frame starts on the vsync falling edge. In that same cycle the flags already
  // count as cleared, so an overlap on the first pixel of the frame is not lost.
  assign frame_start = v_sync_d & ~v_sync_i;
  assign active      = en_i & rst_n;
  assign ov_me       = {LAYERS{active & me_alpha_i}}     & enemy_alpha_i;
  assign ov_bu       = {LAYERS{active & bullet_alpha_i}} & enemy_alpha_i;
  assign me_ok       = (inv_cnt == '0) & (~me_done | frame_start);

  // Only the lowest-index layer gets a me hit. Me hits win over bullet hits on the same layer.
  always_comb begin
    logic found;
    me_pick = '0;
    found   = 1'b0;
    for (int k = 0; k < LAYERS; k++) begin
      if (ov_me[k] && !found) begin
        me_pick[k] = me_ok;
        found      = 1'b1;
      end
    end
    bu_pick = ov_bu & (~bullet_done | {LAYERS{frame_start}}) & ~me_pick;
  end

  assign crash_me_enemy_o     = me_pick;
  assign crash_enemy_bullet_o = bu_pick;
  assign me_hit_o             = |me_pick;
  assign invincible_o         = (inv_cnt != '0);

  // vsync history is tracked even while disabled, so the edge is still seen right after enable.
  always_ff @(posedge clk_vga) begin
    if (!rst_n) v_sync_d <= 1'b1;
    else        v_sync_d <= v_sync_i;
  end

  // Per-frame flags. A pulse sets its flag even in the frame_start cycle; otherwise frame_start clears it.
  always_ff @(posedge clk_vga) begin
    if (!rst_n || !en_i) begin
      bullet_done <= '0;
      me_done     <= 1'b0;
    end else begin
      for (int k = 0; k < LAYERS; k++) begin
        if (bu_pick[k])       bullet_done[k] <= 1'b1;
        else if (frame_start) bullet_done[k] <= 1'b0;
      end
      if (me_hit_o)         me_done <= 1'b1;
      else if (frame_start) me_done <= 1'b0;
    end
  end

  // Invincibility counts frames. Only reset clears it; disabling the game just pauses new hits.
  always_ff @(posedge clk_vga) begin
    if (!rst_n)                              inv_cnt <= '0;
    else if (me_hit_o)                       inv_cnt <= INV_LOAD;
    else if (frame_start && inv_cnt != '0)   inv_cnt <= inv_cnt - 1'b1;
  end

endmodule
